// File: rtl/stf_seq_ctrl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stf_seq_ctrl_pkg                                             |
// | Description : Shared TX definitions for the STF sequencer: the STF period  |
// |               length, the I/Q component width, the sequencer state enum    |
// |               and a per-component halving helper.                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package stf_seq_ctrl_pkg;

  // Samples in one short-training-field period.
  localparam int STF_LEN = 16;

  // Width of each I or Q component in a packed sample word.
  localparam int IQ_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Arithmetic shift right by one on I and Q independently. The sign of each
  // component is preserved, so negative values round toward minus infinity.
  function automatic logic [2*IQ_W-1:0] halve_iq(input logic [2*IQ_W-1:0] s);
    logic signed [IQ_W-1:0] comp_i;
    logic signed [IQ_W-1:0] comp_q;
    comp_i = s[2*IQ_W-1:IQ_W];
    comp_q = s[IQ_W-1:0];
    return {comp_i >>> 1, comp_q >>> 1};
  endfunction

endpackage
`default_nettype wire

// File: rtl/stf_rom1.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stf_rom1                                                     |
// | Description : 16-entry STF sample ROM, combinational read.                 |
// |               Each word is {I[31:16], Q[15:0]}, two's complement.          |
// |               The table is a constant-envelope (1066) sequence whose       |
// |               phase advances by pi/8 per address, with address 6 at 0 rad. |
// | Ports       : addr [3:0]  in  - sample index                               |
// |               dout [31:0] out - packed I/Q sample                          |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stf_rom1 (
  input  logic [3:0]  addr,
  output logic [31:0] dout
);

  always_comb begin
    dout = 32'h0000_0000;
    case (addr)
      4'd0:  dout = 32'hfd0e_fd0e;
      4'd1:  dout = 32'hfe68_fc27;
      4'd2:  dout = 32'h0000_fbd6;
      4'd3:  dout = 32'h0198_fc27;
      4'd4:  dout = 32'h02f2_fd0e;
      4'd5:  dout = 32'h03d9_fe68;
      4'd6:  dout = 32'h042a_0000;
      4'd7:  dout = 32'h03d9_0198;
      4'd8:  dout = 32'h02f2_02f2;
      4'd9:  dout = 32'h0198_03d9;
      4'd10: dout = 32'h0000_042a;
      4'd11: dout = 32'hfe68_03d9;
      4'd12: dout = 32'hfd0e_02f2;
      4'd13: dout = 32'hfc27_0198;
      4'd14: dout = 32'hfbd6_0000;
      4'd15: dout = 32'hfc27_fe68;
      default: dout = 32'h0000_0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/stf_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : stf_seq_ctrl                                                 |
// | Description : Sequences the STF ROM into a valid/ready sample stream of    |
// |               N_REP periods of 16 samples. Optionally halves the very      |
// |               first sample of a burst. Sits between the TX control FSM     |
// |               (start/abort) and the TX sample mux.                         |
// | Ports       : clk            in  - system clock                            |
// |               rstn           in  - asynchronous active-low reset           |
// |               start          in  - one-cycle pulse, begins a burst if idle |
// |               abort          in  - ends the burst at once, no done         |
// |               out_data [31:0] out - {I, Q} sample                          |
// |               out_valid      out - out_data valid                          |
// |               out_ready      in  - downstream accepts on valid & ready     |
// |               busy           out - burst in progress                       |
// |               done           out - pulse when the last sample is accepted  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module stf_seq_ctrl
  import stf_seq_ctrl_pkg::*;
#(
  parameter int N_REP     = 10,
  parameter bit WINDOW_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        start,
  input  logic        abort,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  localparam int ADDR_W = $clog2(STF_LEN);
  localparam int REP_W  = $clog2(N_REP + 1);

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(STF_LEN - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(N_REP);

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] addr_nx;
  logic [REP_W-1:0]  rep;
  logic [REP_W-1:0]  rep_nx;
  logic              first;
  logic              first_nx;
  logic [31:0]       data_nx;
  logic              valid_nx;
  logic              done_nx;

  logic [31:0]       rom_word;
  logic              remaining;
  logic              accept;
  logic              load;

  stf_rom1 u_rom (
    .addr (addr),
    .dout (rom_word)
  );

  // rep reaches N_REP exactly when the final sample has been loaded into the
  // output register, so it doubles as the "no more loads" flag.
  assign remaining = (rep != REP_LAST);
  assign accept    = out_valid & out_ready;
  // The output register may take a new word when it is empty or is being
  // drained this cycle.
  assign load      = (state == RUN) & (~out_valid | out_ready) & remaining;

  assign busy      = (state == RUN);

  always_comb begin
    state_nx = state;
    addr_nx  = addr;
    rep_nx   = rep;
    first_nx = first;
    data_nx  = out_data;
    valid_nx = out_valid;
    done_nx  = 1'b0;

    case (state)
      IDLE: begin
        // abort is ignored here, so start alone decides the transition.
        if (start) begin
          state_nx = RUN;
          addr_nx  = '0;
          rep_nx   = '0;
          first_nx = 1'b1;
        end
      end

      RUN: begin
        if (abort) begin
          // abort outranks a coincident final handshake: no done pulse.
          state_nx = IDLE;
          addr_nx  = '0;
          rep_nx   = '0;
          first_nx = 1'b0;
          valid_nx = 1'b0;
        end else begin
          if (load) begin
            data_nx  = (WINDOW_EN && first) ? halve_iq(rom_word) : rom_word;
            valid_nx = 1'b1;
            first_nx = 1'b0;
            addr_nx  = addr + 1'b1;
            if (addr == ADDR_LAST) begin
              rep_nx = rep + 1'b1;
            end
          end else if (accept) begin
            valid_nx = 1'b0;
          end

          // Final handshake: the register holds the last sample and it is
          // taken this cycle. start is not looked at in RUN, so a start
          // coinciding with this edge is dropped.
          if (accept && !remaining) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
            valid_nx = 1'b0;
            addr_nx  = '0;
            rep_nx   = '0;
          end
        end
      end

      default: begin
        state_nx = IDLE;
        valid_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      addr      <= '0;
      rep       <= '0;
      first     <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      addr      <= addr_nx;
      rep       <= rep_nx;
      first     <= first_nx;
      out_data  <= data_nx;
      out_valid <= valid_nx;
      done      <= done_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stf_seq_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_stf_seq_ctrl                                              |
// | Description : Self-checking bench for stf_seq_ctrl. A plain instance       |
// |               carries the stream/backpressure/abort/reset scenarios; a     |
// |               second instance with windowing enabled checks the halved     |
// |               first sample. Expected samples come from a phase-rotation   |
// |               model and are queued when start is driven.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_stf_seq_ctrl;

  localparam int NREP  = 10;
  localparam int NSAMP = 16 * NREP;

  logic        clk       = 1'b0;
  logic        rstn      = 1'b0;
  logic        start     = 1'b0;
  logic        abort     = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic        out_valid;
  logic        busy;
  logic        done;

  logic        start_w   = 1'b0;
  logic [31:0] data_w;
  logic        valid_w;
  logic        busy_w;
  logic        done_w;

  int          total      = 0;
  int          bad        = 0;
  int          acc        = 0;
  int          acc_w      = 0;
  int          done_cnt   = 0;
  int          done_w_cnt = 0;
  int          cyc        = 0;
  int          first_cyc  = 0;
  int          last_cyc   = 0;
  logic        stalled    = 1'b0;
  logic [31:0] stall_data = 32'h0;
  logic [31:0] q[$];
  logic [31:0] cap   [0:NSAMP-1];
  logic [31:0] cap_w [0:NSAMP-1];

  always #5 clk = ~clk;

  stf_seq_ctrl #(.N_REP(NREP), .WINDOW_EN(1'b0)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .abort     (abort),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  stf_seq_ctrl #(.N_REP(NREP), .WINDOW_EN(1'b1)) dut_w (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start_w),
    .abort     (1'b0),
    .out_data  (data_w),
    .out_valid (valid_w),
    .out_ready (1'b1),
    .busy      (busy_w),
    .done      (done_w)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic int rnd(real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(-x + 0.5);
  endfunction

  // Reference sample: amplitude 1066, phase (n-6)*pi/8.
  function automatic logic [31:0] ref_sample(int n);
    real         ang;
    logic [15:0] iv;
    logic [15:0] qv;
    ang = 3.14159265358979 * real'(n - 6) / 8.0;
    iv  = 16'(rnd(1066.0 * $cos(ang)));
    qv  = 16'(rnd(1066.0 * $sin(ang)));
    return {iv, qv};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: observe at the falling edge, return just after the rising edge.
  task automatic cycle();
    logic [31:0] e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      chk("sb_has_entry", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stream", out_data, e);
      end
      if (acc < NSAMP) cap[acc] = out_data;
      if (acc == 0) first_cyc = cyc;
      last_cyc = cyc;
      acc++;
    end
    if (out_valid && !out_ready) begin
      if (stalled) chk("stall_hold", out_data, stall_data);
      stalled    = 1'b1;
      stall_data = out_data;
    end else begin
      stalled = 1'b0;
    end
    if (done) begin
      done_cnt++;
      chk("done_busy", {31'd0, busy}, 32'd0);
      chk("done_valid", {31'd0, out_valid}, 32'd0);
      chk("done_count", acc, NSAMP);
    end
    if (valid_w) begin
      if (acc_w < NSAMP) cap_w[acc_w] = data_w;
      acc_w++;
    end
    if (done_w) begin
      done_w_cnt++;
      chk("done_w_busy", {31'd0, busy_w}, 32'd0);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (acc < n && k < budget) begin
      cycle();
      k++;
    end
    chk(tag, acc, n);
  endtask

  task automatic start_burst();
    for (int k = 0; k < NSAMP; k++) q.push_back(ref_sample(k % 16));
    acc      = 0;
    done_cnt = 0;
    start    = 1'b1;
    cycle();
    start = 1'b0;
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    chk("valid_after_start", {31'd0, out_valid}, 32'd0);
    cycle();
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    chk("latency_data", out_data, ref_sample(0));
  endtask

  initial begin
    // Reset state.
    repeat (3) cycle();
    chk("rst_data", out_data, 32'h0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rstn = 1'b1;
    repeat (2) cycle();

    // Basic burst at full throughput.
    start_burst();
    wait_acc(NSAMP, 400, "basic_count");
    repeat (3) cycle();
    chk("basic_done_cnt", done_cnt, 1);
    chk("basic_busy_end", {31'd0, busy}, 32'd0);
    chk("basic_q_empty", q.size(), 0);
    chk("basic_s0", cap[0], 32'hfd0e_fd0e);
    chk("basic_s6", cap[6], 32'h042a_0000);
    chk("basic_s15", cap[15], 32'hfc27_fe68);
    chk("basic_s16", cap[16], 32'hfd0e_fd0e);
    chk("basic_throughput", last_cyc - first_cyc, NSAMP - 1);

    // Windowed first sample on the second instance.
    acc_w      = 0;
    done_w_cnt = 0;
    start_w    = 1'b1;
    cycle();
    start_w = 1'b0;
    for (int k = 0; k < 400 && acc_w < NSAMP; k++) cycle();
    repeat (3) cycle();
    chk("win_count", acc_w, NSAMP);
    chk("win_done_cnt", done_w_cnt, 1);
    chk("win_s0", cap_w[0], 32'hfe87_fe87);
    chk("win_s1", cap_w[1], ref_sample(1));
    chk("win_s15", cap_w[15], ref_sample(15));
    chk("win_s16", cap_w[16], 32'hfd0e_fd0e);
    chk("win_s159", cap_w[NSAMP-1], ref_sample(15));

    // Backpressure on sample 7.
    start_burst();
    wait_acc(7, 50, "bp_reach7");
    out_ready = 1'b0;
    repeat (5) begin
      cycle();
      chk("bp_data", out_data, 32'h03d9_0198);
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    wait_acc(NSAMP, 400, "bp_count");
    repeat (3) cycle();
    chk("bp_done_cnt", done_cnt, 1);
    chk("bp_q_empty", q.size(), 0);
    chk("bp_s7", cap[7], 32'h03d9_0198);
    chk("bp_s8", cap[8], ref_sample(8));

    // Abort with the 50th sample being accepted on the same edge.
    start_burst();
    wait_acc(49, 100, "ab_reach49");
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("ab_acc", acc, 50);
    chk("ab_valid", {31'd0, out_valid}, 32'd0);
    chk("ab_busy", {31'd0, busy}, 32'd0);
    chk("ab_done", {31'd0, done}, 32'd0);
    chk("ab_q_left", q.size(), NSAMP - 50);
    q.delete();
    repeat (5) cycle();
    chk("ab_no_done", done_cnt, 0);
    chk("ab_no_more", acc, 50);
    start_burst();
    wait_acc(NSAMP, 400, "ab_restart_count");
    repeat (3) cycle();
    chk("ab_restart_done", done_cnt, 1);
    chk("ab_restart_s0", cap[0], 32'hfd0e_fd0e);

    // start while busy and start coincident with done are ignored.
    start_burst();
    wait_acc(30, 100, "ig_reach30");
    start = 1'b1;
    cycle();
    start = 1'b0;
    wait_acc(NSAMP - 1, 400, "ig_reach_last");
    start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (20) cycle();
    chk("ig_count", acc, NSAMP);
    chk("ig_done_cnt", done_cnt, 1);
    chk("ig_busy", {31'd0, busy}, 32'd0);
    chk("ig_valid", {31'd0, out_valid}, 32'd0);
    chk("ig_q_empty", q.size(), 0);

    // Asynchronous reset mid-burst.
    start_burst();
    wait_acc(80, 200, "rs_reach80");
    #1 rstn = 1'b0;
    #1;
    chk("rs_data", out_data, 32'h0);
    chk("rs_valid", {31'd0, out_valid}, 32'd0);
    chk("rs_busy", {31'd0, busy}, 32'd0);
    chk("rs_done", {31'd0, done}, 32'd0);
    q.delete();
    repeat (2) cycle();
    rstn = 1'b1;
    cycle();
    chk("rs_no_done", done_cnt, 0);
    start_burst();
    wait_acc(NSAMP, 400, "rs_restart_count");
    repeat (3) cycle();
    chk("rs_restart_done", done_cnt, 1);
    chk("rs_q_empty", q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
